// File: rtl/dsp_mac_sequencer.sv
// Sequencer that turns a command plus a valid/ready operand stream into MAC slice pin activity
// and returns one signed dot-product result per command.
//
// state  | meaning
// GUARD  | two cycles after reset, flushes the slice's ACC_EN delay line
// IDLE   | waiting for a command
// CLEAR  | loads the bias into the slice accumulator
// STREAM | forwards operand pairs to the slice
// DRAIN  | waits out the slice's multiply/accumulate pipeline, then captures the result
// RESULT | holds the result until it is consumed
module dsp_mac_sequencer #(
    parameter int WIDTH_OP1 = 18,
    parameter int WIDTH_OP2 = 18,
    parameter int WIDTH_OUT = 48,
    parameter int WIDTH_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [WIDTH_LEN-1:0] CMD_LEN,
    input  logic [WIDTH_OUT-1:0] CMD_BIAS,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH_OP1-1:0] IN_A,
    input  logic [WIDTH_OP2-1:0] IN_B,
    output logic                 DSP_EN,
    output logic                 DSP_ACC_EN,
    output logic                 DSP_ACC_IN_EN,
    output logic [WIDTH_OP1-1:0] DSP_OP1,
    output logic [WIDTH_OP2-1:0] DSP_OP2,
    output logic [WIDTH_OUT-1:0] DSP_ACC,
    input  logic [WIDTH_OUT-1:0] DSP_OUT,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [WIDTH_OUT-1:0] RES_DATA
);

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    localparam logic [1:0]           GUARD_TC = 2'd1;
    localparam logic [1:0]           DRAIN_TC = 2'd2;
    localparam logic [WIDTH_LEN-1:0] LEN_ONE  = WIDTH_LEN'(1);

    state_t               state_q, state_d;
    logic [1:0]           tmr_q, tmr_d;
    logic [WIDTH_LEN-1:0] rem_q, rem_d;
    logic [WIDTH_OUT-1:0] bias_q, bias_d;
    logic [WIDTH_OUT-1:0] res_q, res_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= GUARD;
            tmr_q   <= GUARD_TC;
            rem_q   <= '0;
            bias_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            bias_q  <= bias_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        rem_d         = rem_q;
        bias_d        = bias_q;
        res_d         = res_q;
        CMD_READY     = 1'b0;
        IN_READY      = 1'b0;
        DSP_ACC_EN    = 1'b0;
        DSP_ACC_IN_EN = 1'b0;
        DSP_OP1       = '0;
        DSP_OP2       = '0;
        DSP_ACC       = '0;
        RES_VALID     = 1'b0;

        case (state_q)
            GUARD: begin
                if (tmr_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 2'd1;
                end
            end
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    rem_d   = CMD_LEN;
                    bias_d  = CMD_BIAS;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                DSP_ACC_IN_EN = 1'b1;
                DSP_ACC       = bias_q;
                if (rem_q == '0) begin
                    state_d = DRAIN;
                    tmr_d   = DRAIN_TC;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    DSP_OP1    = IN_A;
                    DSP_OP2    = IN_B;
                    DSP_ACC_EN = 1'b1;
                    rem_d      = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = DRAIN;
                        tmr_d   = DRAIN_TC;
                    end
                end
            end
            DRAIN: begin
                // Last pair was registered at DRAIN entry; its add lands one edge before this capture.
                if (tmr_q == 2'd0) begin
                    res_d   = DSP_OUT;
                    state_d = RESULT;
                end else begin
                    tmr_d = tmr_q - 2'd1;
                end
            end
            RESULT: begin
                RES_VALID = 1'b1;
                if (RES_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = GUARD;
                tmr_d   = GUARD_TC;
            end
        endcase
    end

    // The slice's ACC_EN delay line runs regardless of EN, so EN stays up outside reset.
    assign DSP_EN   = ~RST;
    assign RES_DATA = res_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural model of the 18x18/48 MAC slice.
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [15:0] CMD_LEN = '0;
    logic [47:0] CMD_BIAS = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [17:0] IN_A = '0;
    logic [17:0] IN_B = '0;
    logic        DSP_EN;
    logic        DSP_ACC_EN;
    logic        DSP_ACC_IN_EN;
    logic [17:0] DSP_OP1;
    logic [17:0] DSP_OP2;
    logic [47:0] DSP_ACC;
    logic [47:0] DSP_OUT;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic [47:0] RES_DATA;

    int n_chk = 0;
    int n_err = 0;

    logic [17:0] va[8];
    logic [17:0] vb[8];

    dsp_mac_sequencer #(
        .WIDTH_OP1(18), .WIDTH_OP2(18), .WIDTH_OUT(48), .WIDTH_LEN(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LEN(CMD_LEN), .CMD_BIAS(CMD_BIAS),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .DSP_EN(DSP_EN), .DSP_ACC_EN(DSP_ACC_EN), .DSP_ACC_IN_EN(DSP_ACC_IN_EN),
        .DSP_OP1(DSP_OP1), .DSP_OP2(DSP_OP2), .DSP_ACC(DSP_ACC), .DSP_OUT(DSP_OUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA)
    );

    always #5 CLK = ~CLK;

    // Slice: operands registered at e, product at e+1, accumulate at e+2; delay line not EN-gated.
    logic signed [17:0] s_r1 = '0;
    logic signed [17:0] s_r2 = '0;
    logic signed [35:0] s_prod = '0;
    logic signed [47:0] s_acc = '0;
    logic               s_d1 = 1'b0;
    logic               s_d2 = 1'b0;

    always @(posedge CLK) begin
        s_d1 <= DSP_ACC_EN;
        s_d2 <= s_d1;
        if (DSP_EN) begin
            s_r1   <= DSP_OP1;
            s_r2   <= DSP_OP2;
            s_prod <= 36'(s_r1) * 36'(s_r2);
            if (DSP_ACC_IN_EN)
                s_acc <= DSP_ACC;
            else if (s_d2)
                s_acc <= s_acc + 48'(s_prod);
        end
    end
    assign DSP_OUT = s_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(
        input  int                 len,
        input  logic signed [47:0] bias,
        input  int                 gap,
        input  int                 hold,
        output logic signed [47:0] res,
        output int                 cyc,
        output int                 accen_n,
        output int                 first_hs,
        output int                 acc_in_n,
        output logic signed [47:0] acc_val,
        output logic               ir_seen,
        output logic               cr_seen,
        output logic               hold_ok
    );
        int   i;
        int   g;
        int   k;
        logic hs;
        logic done;
        res = '0; cyc = 0; accen_n = 0; first_hs = -1; acc_in_n = 0; acc_val = '0;
        ir_seen = 1'b0; cr_seen = 1'b0; hold_ok = 1'b1;
        k = 0;
        while (!CMD_READY && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        chk("cmd_ready_wait", 64'(CMD_READY), 64'd1);
        CMD_VALID = 1'b1;
        CMD_LEN   = 16'(len);
        CMD_BIAS  = bias;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        i = 0; g = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (i < len && g == 0) begin
                IN_VALID = 1'b1; IN_A = va[i]; IN_B = vb[i];
            end else begin
                IN_VALID = 1'b0; IN_A = '0; IN_B = '0;
                if (g > 0) g--;
            end
            @(negedge CLK);
            if (RES_VALID) begin
                done = 1'b1;
                res  = RES_DATA;
            end else begin
                hs = IN_VALID && IN_READY;
                if (IN_READY)   ir_seen = 1'b1;
                if (CMD_READY)  cr_seen = 1'b1;
                if (DSP_ACC_EN) accen_n++;
                if (DSP_ACC_IN_EN) begin
                    acc_in_n++;
                    acc_val = DSP_ACC;
                end
                @(posedge CLK); #1;
                cyc++;
                if (hs) begin
                    if (i == 0) first_hs = cyc;
                    i++;
                    g = gap;
                end
            end
        end
        IN_VALID = 1'b0;
        chk("res_valid_seen", 64'(done), 64'd1);
        if (done) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge CLK); #1;
                if (!(RES_VALID === 1'b1 && RES_DATA === res && CMD_READY === 1'b0))
                    hold_ok = 1'b0;
            end
            RES_READY = 1'b1;
            @(posedge CLK); #1;
            RES_READY = 1'b0;
            chk("post_cmd_ready", 64'(CMD_READY), 64'd1);
            chk("post_res_valid", 64'(RES_VALID), 64'd0);
        end
    endtask

    logic signed [47:0] r;
    logic signed [47:0] av;
    int                 cyc, an, fh, ain;
    logic               irs, crs, hok;
    int                 k;

    initial begin
        #12;
        chk("rst_cmd_ready", 64'(CMD_READY), 64'd0);
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_dsp_en", 64'(DSP_EN), 64'd0);
        chk("rst_acc_en", 64'(DSP_ACC_EN), 64'd0);
        chk("rst_acc_in_en", 64'(DSP_ACC_IN_EN), 64'd0);
        chk("rst_op1", 64'(DSP_OP1), 64'd0);
        chk("rst_op2", 64'(DSP_OP2), 64'd0);
        chk("rst_acc", 64'(DSP_ACC), 64'd0);
        chk("rst_res_valid", 64'(RES_VALID), 64'd0);
        chk("rst_res_data", 64'(RES_DATA), 64'd0);
        @(posedge CLK); #3;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("guard_cycle1", 64'(CMD_READY), 64'd0);
        chk("dsp_en_run", 64'(DSP_EN), 64'd1);
        @(posedge CLK); #1;
        chk("guard_done", 64'(CMD_READY), 64'd1);

        // 10 + 1*4 + 2*5 + 3*6 = 42
        va[0] = 18'sd1; va[1] = 18'sd2; va[2] = 18'sd3;
        vb[0] = 18'sd4; vb[1] = 18'sd5; vb[2] = 18'sd6;
        run_cmd(3, 48'sd10, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t1_res", 64'(r), 64'(48'sd42));
        chk("t1_latency", 64'(cyc), 64'd7);
        chk("t1_acc_en_n", 64'(an), 64'd3);
        chk("t1_first_hs", 64'(fh), 64'd2);
        chk("t1_clear_n", 64'(ain), 64'd1);
        chk("t1_bias_load", 64'(av), 64'(48'sd10));
        chk("t1_cmd_ready_busy", 64'(crs), 64'd0);

        va[0] = -18'sd3; vb[0] = 18'sd7;
        run_cmd(1, 48'sd0, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t2_res", 64'(r), 64'(-48'sd21));
        chk("t2_latency", 64'(cyc), 64'd5);

        va[0] = 18'h20000; va[1] = 18'h20000;
        vb[0] = 18'h20000; vb[1] = 18'h20000;
        run_cmd(2, 48'sd0, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t3_res_2p35", 64'(r), 64'(48'sh8_0000_0000));

        // Two idle cycles between each pair add six edges to the nominal 8.
        for (int i = 0; i < 4; i++) begin
            va[i] = 18'sd1; vb[i] = 18'sd1;
        end
        run_cmd(4, 48'sd0, 2, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t4_res", 64'(r), 64'(48'sd4));
        chk("t4_acc_en_n", 64'(an), 64'd4);
        chk("t4_latency", 64'(cyc), 64'd14);

        run_cmd(0, -48'sd5, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t5_res", 64'(r), 64'(-48'sd5));
        chk("t5_latency", 64'(cyc), 64'd4);
        chk("t5_in_ready", 64'(irs), 64'd0);
        chk("t5_acc_en_n", 64'(an), 64'd0);

        // 7 + 3*4 + (-2)*5 = 9, result held for five cycles
        va[0] = 18'sd3; va[1] = -18'sd2;
        vb[0] = 18'sd4; vb[1] = 18'sd5;
        run_cmd(2, 48'sd7, 0, 5, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t6_res", 64'(r), 64'(48'sd9));
        chk("t6_hold_stable", 64'(hok), 64'd1);
        va[0] = 18'sd2; vb[0] = 18'sd3;
        run_cmd(1, 48'sd0, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t6_b2b_res", 64'(r), 64'(48'sd6));

        k = 0;
        while (!CMD_READY && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        CMD_VALID = 1'b1; CMD_LEN = 16'd3; CMD_BIAS = 48'sd100;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b1; IN_A = 18'sd5; IN_B = 18'sd5;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 64'(CMD_READY), 64'd0);
        chk("mid_rst_in_ready", 64'(IN_READY), 64'd0);
        chk("mid_rst_res_valid", 64'(RES_VALID), 64'd0);
        chk("mid_rst_dsp_en", 64'(DSP_EN), 64'd0);
        chk("mid_rst_res_data", 64'(RES_DATA), 64'd0);
        @(posedge CLK); #3;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("mid_guard_cycle1", 64'(CMD_READY), 64'd0);
        @(posedge CLK); #1;
        chk("mid_guard_cycle2", 64'(CMD_READY), 64'd1);
        // 1 + 2*4 + 3*5 = 24
        va[0] = 18'sd2; va[1] = 18'sd3;
        vb[0] = 18'sd4; vb[1] = 18'sd5;
        run_cmd(2, 48'sd1, 0, 0, r, cyc, an, fh, ain, av, irs, crs, hok);
        chk("t7_res", 64'(r), 64'(48'sd24));
        chk("t7_latency", 64'(cyc), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
